// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter that sits on the data-memory
// port next to dmem. It decodes a 16-byte register window at BASE_ADDR.
//   offset 0x0 TXDATA : write pushes WriteDataM[7:0] into the TX FIFO; reads 0
//   offset 0x4 STATUS : {count_sat[3:0], overflow, busy, empty, full}; write 1 to bit3 clears overflow
//   offset 0x8 DIV    : clocks per bit, 16 bits; 0 is treated as 1
//   offset 0xC        : reserved; reads 0, writes ignored
// Ports:
//   clk        system clock (rising edge)
//   rst        asynchronous active-low reset
//   MemWriteM  store strobe from the Memory stage
//   DataAdrM   byte address from the Memory stage
//   WriteDataM store data from the Memory stage
//   io_sel     combinational window select
//   io_rdata   combinational register read data (0 when not selected)
//   tx         registered serial output, idles high
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned CLK_DIV_RST = 16,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWriteM,
  input  logic [31:0] DataAdrM,
  input  logic [31:0] WriteDataM,
  output logic        io_sel,
  output logic [31:0] io_rdata,
  output logic        tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] fcount;
  logic [31:0] count_wide;
  logic [3:0]  count_sat;
  logic        full;
  logic        empty;
  logic [7:0]  head;

  logic [1:0]  reg_sel;
  logic        wr_en;
  logic        push_req;
  logic        push;
  logic        pop;

  logic        overflow;
  logic [15:0] div_reg;
  logic [15:0] div_eff;

  logic [1:0]  state;
  logic        busy;
  logic [15:0] cnt;
  logic [7:0]  shift;
  logic [2:0]  bit_idx;

  // Address byte lanes and upper store bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{DataAdrM[1:0], WriteDataM[31:16]};

  // Decode
  assign io_sel   = (DataAdrM[31:4] == BASE_ADDR[31:4]);
  assign reg_sel  = DataAdrM[3:2];
  assign wr_en    = MemWriteM && io_sel;
  assign push_req = wr_en && (reg_sel == 2'd0);
  assign push     = push_req && !full;

  // FIFO status from extra-MSB pointers
  assign fcount     = wptr - rptr;
  assign empty      = (wptr == rptr);
  assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count_wide = 32'(fcount);
  assign count_sat  = (count_wide > 32'd15) ? 4'hF : count_wide[3:0];
  assign head       = mem[rptr[AW-1:0]];

  assign busy    = (state != S_IDLE);
  assign pop     = (state == S_IDLE) && !empty;
  assign div_eff = (div_reg == 16'd0) ? 16'd1 : div_reg;

  // Register read mux
  always_comb begin
    io_rdata = '0;
    if (io_sel) begin
      case (reg_sel)
        2'd1:    io_rdata = {24'd0, count_sat, overflow, busy, empty, full};
        2'd2:    io_rdata = {16'd0, div_reg};
        default: io_rdata = '0;
      endcase
    end
  end

  // FIFO storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= WriteDataM[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      div_reg  <= 16'(CLK_DIV_RST);
    end else begin
      if (push_req && full) begin
        overflow <= 1'b1;
      end else if (wr_en && (reg_sel == 2'd1) && WriteDataM[3]) begin
        overflow <= 1'b0;
      end
      if (wr_en && (reg_sel == 2'd2)) begin
        div_reg <= WriteDataM[15:0];
      end
    end
  end

  // Transmit FSM. cnt counts down the cycles left in the current bit and is
  // reloaded from div_eff at every bit boundary, so DIV changes take effect
  // only on the next bit. tx is loaded with the level of the state entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      cnt     <= '0;
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            shift <= head;
            cnt   <= div_eff;
            tx    <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (cnt == 16'd1) begin
            cnt     <= div_eff;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= S_DATA;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (cnt == 16'd1) begin
            cnt   <= div_eff;
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (cnt == 16'd1) begin
            tx    <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx. Stimulus pushes expected frames (byte plus bit
// durations) into a queue; a separate monitor watches tx, pops the queue on
// each start bit and compares the serial waveform cycle by cycle.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] A_TXD  = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'd4;
  localparam logic [31:0] A_DIV  = BASE + 32'd8;
  localparam logic [31:0] A_RSV  = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] DataAdrM = '0;
  logic [31:0] WriteDataM = '0;
  logic        io_sel;
  logic [31:0] io_rdata;
  logic        tx;

  int unsigned total = 0;
  int unsigned bad = 0;

  // d1 applies to frame bit positions < sw (0=start,1..8=data,9=stop), d2 from sw on.
  typedef struct packed {
    logic [7:0] data;
    int         d1;
    int         d2;
    int         sw;
    int         gap;
  } frame_t;

  frame_t exp_q[$];
  logic   mon_en = 1'b0;
  logic   mon_busy = 1'b0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR(BASE),
    .CLK_DIV_RST(16),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .MemWriteM(MemWriteM),
    .DataAdrM(DataAdrM),
    .WriteDataM(WriteDataM),
    .io_sel(io_sel),
    .io_rdata(io_rdata),
    .tx(tx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] status_word(input int cnt, input bit ovf, input bit bsy);
    logic [3:0] c4;
    c4 = (cnt > 15) ? 4'hF : 4'(cnt);
    return {24'd0, c4, ovf, bsy, (cnt == 0), (cnt == 8)};
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWriteM  = 1'b1;
    DataAdrM   = a;
    WriteDataM = d;
    @(negedge clk);
    MemWriteM  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic s);
    DataAdrM = a;
    #1;
    d = io_rdata;
    s = io_sel;
  endtask

  task automatic exp_frame(input logic [7:0] b, input int div, input int gap);
    frame_t f;
    f.data = b;
    f.d1   = div;
    f.d2   = div;
    f.sw   = 10;
    f.gap  = gap;
    exp_q.push_back(f);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_pending_frames"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: decodes frames from tx and compares against the queue head.
  initial begin : monitor
    int idle_run;
    idle_run = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        idle_run = 0;
      end else if (tx === 1'b1) begin
        idle_run++;
      end else begin
        frame_t     f;
        logic [9:0] lv;
        logic       ok;
        int         bad_bit;
        logic       got;
        int         n;
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got start bit tx=0 expected idle tx=1");
          n = 0;
          while (tx !== 1'b1 && n < 100000) begin
            @(negedge clk);
            n++;
          end
        end else begin
          f = exp_q.pop_front();
          if (f.gap >= 0) check($sformatf("gap_before_%02h", f.data), idle_run, f.gap);
          lv      = {1'b1, f.data, 1'b0};
          ok      = 1'b1;
          bad_bit = -1;
          got     = 1'b0;
          for (int b = 0; b < 10; b++) begin
            int d;
            d = (b >= f.sw) ? f.d2 : f.d1;
            for (int c = 0; c < d; c++) begin
              if (!(b == 0 && c == 0)) @(negedge clk);
              if (ok && tx !== lv[b]) begin
                ok      = 1'b0;
                bad_bit = b;
                got     = tx;
              end
            end
          end
          total++;
          if (!ok) begin
            bad++;
            $display("FAIL frame_%02h: bit position %0d got tx=%b expected %b",
                     f.data, bad_bit, got, lv[bad_bit]);
          end
        end
        idle_run = 0;
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] d;
    logic        s;
    int          cnt;
    int          r;
    int          n;
    frame_t      f;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_tx", {31'd0, tx}, 1);
    rd(A_STAT, d, s);
    check("reset_status", d, status_word(0, 0, 0));
    check("reset_sel", {31'd0, s}, 1);
    rd(A_DIV, d, s);
    check("reset_div", d, 16);

    // Asynchronous reset while the frame is in its data bits
    wr(A_DIV, 4);
    wr(A_TXD, 32'h5A);
    repeat (12) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_tx", {31'd0, tx}, 1);
    rd(A_STAT, d, s);
    check("midreset_status", d, status_word(0, 0, 0));
    rd(A_DIV, d, s);
    check("midreset_div", d, 16);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) cnt++;
    end
    check("postreset_low_cycles", cnt, 0);
    rd(A_STAT, d, s);
    check("postreset_status", d, status_word(0, 0, 0));
    mon_en = 1'b1;
    @(negedge clk);

    // Single byte at DIV=4: latency and busy window
    wr(A_DIV, 4);
    exp_frame(8'h55, 4, -1);
    wr(A_TXD, 32'h55);
    check("latency_edge1_tx", {31'd0, tx}, 1);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) check("latency_edge2_tx", {31'd0, tx}, 0);
      rd(A_STAT, d, s);
      if (d[2]) cnt++;
    end
    check("busy_cycles", cnt, 40);
    drain("single");

    // Back-to-back at DIV=1
    wr(A_DIV, 1);
    exp_frame(8'hA5, 1, -1);
    exp_frame(8'h3C, 1, 1);
    wr(A_TXD, 32'hA5);
    wr(A_TXD, 32'h3C);
    rd(A_STAT, d, s);
    check("b2b_status", d, status_word(1, 0, 1));
    drain("b2b");

    // Overflow: one byte in flight, then nine pushes into an 8-deep FIFO
    wr(A_DIV, 64);
    exp_frame(8'h10, 64, -1);
    wr(A_TXD, 32'h10);
    n = 0;
    d = '0;
    while (!d[2] && n < 8) begin
      @(negedge clk);
      rd(A_STAT, d, s);
      n++;
    end
    check("ovf_busy_seen", {31'd0, d[2]}, 1);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_frame(8'(8'h20 + i), 64, 1);
      wr(A_TXD, 32'h20 + i);
    end
    rd(A_STAT, d, s);
    check("ovf_status", d, status_word(8, 1, 1));
    wr(A_STAT, 32'h8);
    rd(A_STAT, d, s);
    check("ovf_cleared_status", d, status_word(8, 0, 1));
    drain("ovf");

    // DIV change during data bit 3
    wr(A_DIV, 8);
    f.data = 8'hC3;
    f.d1   = 8;
    f.d2   = 2;
    f.sw   = 5;
    f.gap  = -1;
    exp_q.push_back(f);
    wr(A_TXD, 32'hC3);
    repeat (34) @(negedge clk);
    wr(A_DIV, 2);
    rd(A_DIV, d, s);
    check("div_midbit_readback", d, 2);
    drain("div_midbit");

    // DIV=0 acts as 1
    wr(A_DIV, 0);
    rd(A_DIV, d, s);
    check("div_zero_readback", d, 0);
    exp_frame(8'h96, 1, -1);
    wr(A_TXD, 32'h96);
    drain("div_zero");

    // Decode
    rd(32'h0FFF_FFFC, d, s);
    check("below_window_sel", {31'd0, s}, 0);
    check("below_window_rdata", d, 0);
    rd(32'h1000_0010, d, s);
    check("above_window_sel", {31'd0, s}, 0);
    check("above_window_rdata", d, 0);
    rd(A_TXD, d, s);
    check("txdata_reads_zero", d, 0);
    wr(A_RSV, 32'hFFFF_FFFF);
    wr(32'h1000_0010, 32'h77);
    wr(32'h0FFF_FFFC, 32'h78);
    rd(A_RSV, d, s);
    check("reserved_reads_zero", d, 0);
    rd(A_DIV, d, s);
    check("div_after_reserved_write", d, 0);
    repeat (4) @(negedge clk);
    rd(A_STAT, d, s);
    check("status_after_ignored_writes", d, status_word(0, 0, 0));
    exp_frame(8'hE7, 1, -1);
    wr(BASE + 32'd3, 32'hFFFF_FFE7);
    drain("lane_ignored");

    // Randomized batches, each fitting in the FIFO behind the byte in flight
    for (int bt = 0; bt < 6; bt++) begin
      r = $urandom_range(1, 3);
      wr(A_DIV, r);
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        exp_frame(b, r, -1);
        wr(A_TXD | 32'($urandom_range(0, 3)), {24'($urandom), b});
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain($sformatf("rand%0d", bt));
    end

    rd(A_STAT, d, s);
    check("final_status", d, status_word(0, 0, 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
